// File: rtl/hamming_scrubber_15_11.sv
// Background scrubber and port arbiter for a single-port RAM of Hamming(15,11) SEC words.
// The user port always wins the RAM; the scrubber reads, corrects and writes back in the gaps.
module hamming_scrubber_15_11 #(
    parameter int ADDR_W       = 6,
    parameter int SCRUB_PERIOD = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scrub_en_i,
    input  logic              user_req_i,
    input  logic              user_we_i,
    input  logic [ADDR_W-1:0] user_addr_i,
    input  logic [14:0]       user_wdata_i,
    output logic              user_gnt_o,
    output logic              user_rvalid_o,
    output logic [14:0]       user_rdata_o,
    output logic              user_sec_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [14:0]       mem_wdata_o,
    input  logic [14:0]       mem_rdata_i,
    output logic              scrub_busy_o,
    output logic              scrub_pass_o,
    output logic [15:0]       err_count_o
);
    // state | meaning
    // WAIT  | idle, period timer running while enabled
    // RD    | scrub read pending until the port is free
    // CHK   | scrub read data returning, corrected and checked
    // WB    | corrected word waiting to be written back
    typedef enum logic [1:0] {ST_WAIT, ST_RD, ST_CHK, ST_WB} state_t;

    localparam int TMR_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
    logic [14:0]       fix_word_q, fix_word_d;
    logic              scrub_pass_q, scrub_pass_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              user_rd_pend_q, user_rd_pend_d;
    logic              user_rvalid_q, user_rvalid_d;
    logic [14:0]       user_rdata_q, user_rdata_d;
    logic              user_sec_q, user_sec_d;

    logic [3:0]  syn;
    logic        rd_sec;
    logic [14:0] rd_word;
    logic        user_wr_hit;
    logic        advance;
    logic        scrub_sec;
    logic [16:0] err_sum;

    always_comb begin
        syn = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mem_rdata_i[i]) syn = syn ^ 4'(i + 1);
        end
        rd_sec  = (syn != 4'd0);
        rd_word = rd_sec ? (mem_rdata_i ^ (15'd1 << (syn - 4'd1))) : mem_rdata_i;
    end

    assign user_wr_hit = user_req_i && user_we_i && (user_addr_i == scrub_addr_q);

    // Scrub accesses are suppressed while in reset so a pending writeback never lands.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (user_req_i) begin
            mem_en_o    = 1'b1;
            mem_we_o    = user_we_i;
            mem_addr_o  = user_addr_i;
            mem_wdata_o = user_wdata_i;
        end else if (!rst_i && state_q == ST_RD) begin
            mem_en_o   = 1'b1;
            mem_addr_o = scrub_addr_q;
        end else if (!rst_i && state_q == ST_WB) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = scrub_addr_q;
            mem_wdata_o = fix_word_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        scrub_addr_d = scrub_addr_q;
        fix_word_d   = fix_word_q;
        scrub_pass_d = 1'b0;
        advance      = 1'b0;
        scrub_sec    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (!scrub_en_i) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    state_d = ST_RD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RD: begin
                if (!user_req_i) state_d = ST_CHK;
            end
            ST_CHK: begin
                fix_word_d = rd_word;
                scrub_sec  = rd_sec;
                if (!rd_sec || user_wr_hit) begin
                    advance = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (!user_req_i || user_wr_hit) begin
                    advance = 1'b1;
                    state_d = ST_WAIT;
                end
            end
        endcase
        if (advance) begin
            scrub_addr_d = scrub_addr_q + 1'b1;
            scrub_pass_d = &scrub_addr_q;
        end
    end

    always_comb begin
        user_rd_pend_d = user_req_i && !user_we_i;
        user_rvalid_d  = user_rd_pend_q;
        user_rdata_d   = user_rdata_q;
        user_sec_d     = user_sec_q;
        if (user_rd_pend_q) begin
            user_rdata_d = rd_word;
            user_sec_d   = rd_sec;
        end
        err_sum     = {1'b0, err_count_q} + {16'd0, scrub_sec}
                    + {16'd0, user_rd_pend_q && rd_sec};
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_WAIT;
            timer_q        <= '0;
            scrub_addr_q   <= '0;
            fix_word_q     <= '0;
            scrub_pass_q   <= 1'b0;
            err_count_q    <= '0;
            user_rd_pend_q <= 1'b0;
            user_rvalid_q  <= 1'b0;
            user_rdata_q   <= '0;
            user_sec_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            scrub_addr_q   <= scrub_addr_d;
            fix_word_q     <= fix_word_d;
            scrub_pass_q   <= scrub_pass_d;
            err_count_q    <= err_count_d;
            user_rd_pend_q <= user_rd_pend_d;
            user_rvalid_q  <= user_rvalid_d;
            user_rdata_q   <= user_rdata_d;
            user_sec_q     <= user_sec_d;
        end
    end

    assign user_gnt_o    = user_req_i;
    assign user_rvalid_o = user_rvalid_q;
    assign user_rdata_o  = user_rdata_q;
    assign user_sec_o    = user_sec_q;
    assign scrub_busy_o  = (state_q != ST_WAIT);
    assign scrub_pass_o  = scrub_pass_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_hamming_scrubber_15_11.sv
// Bench for hamming_scrubber_15_11: RAM model, encoder/injector reference and scrub/user scenarios.
module tb_hamming_scrubber_15_11;
    localparam int AW  = 2;
    localparam int PER = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scrub_en = 1'b0;
    logic          user_req = 1'b0;
    logic          user_we = 1'b0;
    logic [AW-1:0] user_addr = '0;
    logic [14:0]   user_wdata = '0;
    logic          user_gnt, user_rvalid, user_sec;
    logic [14:0]   user_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [14:0]   mem_wdata;
    logic [14:0]   ram_rdata;
    logic          scrub_busy, scrub_pass;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    hamming_scrubber_15_11 #(.ADDR_W(AW), .SCRUB_PERIOD(PER)) dut (
        .clk_i(clk), .rst_i(rst), .scrub_en_i(scrub_en),
        .user_req_i(user_req), .user_we_i(user_we), .user_addr_i(user_addr),
        .user_wdata_i(user_wdata), .user_gnt_o(user_gnt), .user_rvalid_o(user_rvalid),
        .user_rdata_o(user_rdata), .user_sec_o(user_sec),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(ram_rdata),
        .scrub_busy_o(scrub_busy), .scrub_pass_o(scrub_pass), .err_count_o(err_count)
    );

    // Single-port RAM with a side door for preloading contents.
    logic [14:0]   ram [4];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [14:0]   pre_data = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_en && !mem_we) ram_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] rd_addr_q[$];
    int            rd_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [14:0]   wr_data_q[$];
    int            wr_cyc_q[$];
    int            pass_cnt = 0;
    always @(negedge clk) begin
        if (mem_en && !user_req) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(cyc);
            end else if (!rst) begin
                rd_addr_q.push_back(mem_addr);
                rd_cyc_q.push_back(cyc);
            end
        end
        if (scrub_pass) pass_cnt = pass_cnt + 1;
    end

    int            total = 0;
    int            bad = 0;
    int            exp_err = 0;
    logic [AW-1:0] exp_addr = '0;
    int            rd_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] w;
        logic [3:0]  s;
        int          k;
        w = '0; s = '0; k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 15; p++) if (w[p-1]) s = s ^ 4'(p);
        for (int b = 0; b < 4; b++) w[(1 << b) - 1] = s[b];
        return w;
    endfunction

    function automatic logic [14:0] flip(input logic [14:0] w, input int b);
        logic [14:0] r;
        r = w;
        r[b] = ~r[b];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [14:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        tick(1);
        pre_we = 1'b0;
    endtask

    task automatic clear_ram();
        for (int a = 0; a < 4; a++) preload(AW'(a), 15'd0);
    endtask

    // Scrub reads must walk the address space in order, one step at a time.
    task automatic sync_reads();
        while (rd_seen < rd_addr_q.size()) begin
            check_eq("scrub_rd_addr", rd_addr_q[rd_seen], exp_addr);
            exp_addr = exp_addr + 1'b1;
            rd_seen++;
        end
    endtask

    task automatic do_reset();
        sync_reads();
        user_req = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_addr = '0;
        exp_err = 0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (scrub_busy && i < 20) begin
            tick(1);
            i++;
        end
        check_eq("idle_reached", scrub_busy, 1'b0);
    endtask

    task automatic user_read(input logic [AW-1:0] a, input logic [14:0] exp_w, input logic exp_s);
        user_req = 1'b1; user_we = 1'b0; user_addr = a;
        tick(1);
        user_req = 1'b0;
        check_eq("rvalid_t1", user_rvalid, 1'b0);
        tick(1);
        check_eq("rvalid_t2", user_rvalid, 1'b1);
        check_eq("rdata", user_rdata, exp_w);
        check_eq("sec", user_sec, exp_s);
        if (exp_s && exp_err < 65535) exp_err++;
        check_eq("err_count", err_count, exp_err);
    endtask

    task automatic wait_new_read(input int n0, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (rd_addr_q.size() > n0) seen = 1'b1;
        end
        check_eq("scrub_rd_seen", seen, 1'b1);
    endtask

    logic [AW-1:0] k;
    logic [14:0]   cw, wd;
    logic          seen, e;
    int            n0, w0, p0, b;

    initial begin
        @(posedge clk); #1;
        clear_ram();
        do_reset();
        check_eq("rst_busy", scrub_busy, 1'b0);
        check_eq("rst_pass", scrub_pass, 1'b0);
        check_eq("rst_err", err_count, 16'd0);
        check_eq("rst_rvalid", user_rvalid, 1'b0);
        check_eq("rst_rdata", user_rdata, 15'd0);
        check_eq("rst_sec", user_sec, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 2'd0);
        check_eq("rst_mem_wdata", mem_wdata, 15'd0);

        // Clean memory: two full passes, evenly spaced reads, no writes.
        n0 = rd_addr_q.size(); p0 = pass_cnt;
        scrub_en = 1'b1;
        for (int i = 0; i < 120 && rd_addr_q.size() < n0 + 9; i++) tick(1);
        check_eq("clean_reads", rd_addr_q.size(), n0 + 9);
        for (int i = n0 + 1; i < n0 + 9 && i < rd_cyc_q.size(); i++)
            check_eq("scrub_gap", rd_cyc_q[i] - rd_cyc_q[i-1], PER + 2);
        tick(1);
        sync_reads();
        check_eq("clean_passes", pass_cnt - p0, 2);
        check_eq("clean_writes", wr_addr_q.size(), 0);
        check_eq("clean_err", err_count, 16'd0);

        // Single-bit error at address 2 gets written back corrected.
        scrub_en = 1'b0;
        wait_idle();
        do_reset();
        preload(2'd2, 15'h0010);
        w0 = wr_addr_q.size();
        scrub_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (wr_addr_q.size() > w0) seen = 1'b1;
        end
        check_eq("wb_seen", seen, 1'b1);
        if (seen && rd_cyc_q.size() > 0) begin
            check_eq("wb_addr", wr_addr_q[w0], 2'd2);
            check_eq("wb_data", wr_data_q[w0], 15'd0);
            check_eq("wb_latency", wr_cyc_q[w0] - rd_cyc_q[rd_cyc_q.size()-1], 2);
        end
        check_eq("wb_ram", ram[2], 15'd0);
        exp_err = 1;
        check_eq("wb_err", err_count, exp_err);

        // Random user reads of clean and single-error words.
        scrub_en = 1'b0;
        wait_idle();
        for (int n = 0; n < 20; n++) begin
            cw = encode(11'($urandom));
            k  = AW'($urandom_range(0, 3));
            e  = (n == 0) || ($urandom_range(0, 1) == 1);
            b  = (n == 0) ? 14 : int'($urandom_range(0, 14));
            preload(k, e ? flip(cw, b) : cw);
            user_read(k, cw, e);
        end

        // User holds the port while the scrubber sits in RD.
        clear_ram();
        scrub_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (scrub_busy) seen = 1'b1;
        end
        check_eq("rd_state_seen", seen, 1'b1);
        n0 = rd_addr_q.size();
        user_req = 1'b1; user_we = 1'b0; user_addr = 2'd3;
        repeat (5) begin
            @(negedge clk); #1;
            check_eq("hold_busy", scrub_busy, 1'b1);
            check_eq("hold_mem_addr", mem_addr, 2'd3);
            check_eq("hold_gnt", user_gnt, user_req);
            @(posedge clk); #1;
        end
        user_req = 1'b0;
        @(negedge clk); #1;
        check_eq("release_rd_issued", rd_addr_q.size(), n0 + 1);
        check_eq("release_mem_en", mem_en, 1'b1);
        check_eq("release_mem_we", mem_we, 1'b0);
        tick(1);

        // User write to the scrub address in the WB cycle cancels the writeback.
        scrub_en = 1'b0;
        wait_idle();
        sync_reads();
        k  = exp_addr;
        cw = encode(11'h2C7);
        wd = encode(11'h13B);
        preload(k, flip(cw, 7));
        n0 = rd_addr_q.size(); w0 = wr_addr_q.size();
        scrub_en = 1'b1;
        wait_new_read(n0, seen);
        tick(1);
        check_eq("wb_cycle_busy", scrub_busy, 1'b1);
        user_req = 1'b1; user_we = 1'b1; user_addr = k; user_wdata = wd;
        tick(1);
        user_req = 1'b0; user_we = 1'b0;
        exp_err++;
        tick(3);
        check_eq("coll_no_wr", wr_addr_q.size(), w0);
        check_eq("coll_ram", ram[k], wd);
        check_eq("coll_err", err_count, exp_err);
        check_eq("coll_idle", scrub_busy, 1'b0);

        // Saturation of the error counter via back-to-back erroneous user reads.
        scrub_en = 1'b0;
        wait_idle();
        cw = encode(11'h5A5);
        preload(2'd1, flip(cw, 9));
        n0 = 65534 - exp_err;
        user_req = 1'b1; user_we = 1'b0; user_addr = 2'd1;
        tick(n0);
        user_req = 1'b0;
        exp_err = 65534;
        tick(2);
        check_eq("err_fffe", err_count, 16'hFFFE);
        user_read(2'd1, cw, 1'b1);
        user_read(2'd1, cw, 1'b1);

        // Reset in the CHK cycle drops the pending writeback.
        wait_idle();
        sync_reads();
        k = exp_addr;
        preload(k, flip(encode(11'h0F0), 3));
        n0 = rd_addr_q.size(); w0 = wr_addr_q.size();
        scrub_en = 1'b1;
        wait_new_read(n0, seen);
        sync_reads();
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("rstchk_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        check_eq("rstchk_busy", scrub_busy, 1'b0);
        check_eq("rstchk_err", err_count, 16'd0);
        check_eq("rstchk_rvalid", user_rvalid, 1'b0);
        check_eq("rstchk_rdata", user_rdata, 15'd0);
        check_eq("rstchk_sec", user_sec, 1'b0);
        check_eq("rstchk_pass", scrub_pass, 1'b0);
        check_eq("rstchk_mem_en", mem_en, 1'b0);
        exp_addr = '0;
        exp_err = 0;
        rst = 1'b0;
        tick(3);
        check_eq("rstchk_no_wr", wr_addr_q.size(), w0);
        sync_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
